// File: rtl/edge_tx_pkg.sv
// Shared constants and FSM state type for the edge-frame UART transmitter.
// Frame geometry defaults describe a 170x240 binarized edge image.
package edge_tx_pkg;

    localparam int unsigned H_RES_DEFAULT = 170;
    localparam int unsigned V_RES_DEFAULT = 240;
    localparam int unsigned TH_DEFAULT    = 128;
    localparam int unsigned NPIX          = H_RES_DEFAULT * V_RES_DEFAULT;
    localparam int unsigned NBYTES        = NPIX / 8;
    localparam logic [7:0]  SYNC_BYTE     = 8'hA5;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned ADDR_W = 13;

    typedef enum logic [2:0] {
        ST_CAP,
        ST_HDR,
        ST_RD,
        ST_PUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/edge_tx_ram.sv
// Simple dual-port frame buffer: one write port, registered read port.
// No reset on storage or read register so it maps onto block RAM.
module edge_tx_ram #(
    parameter int unsigned DEPTH = 5100,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/edge_frame_tx.sv
// Captures one binarized edge frame into a packed byte buffer, then streams
// a sync header followed by the buffer into a UART TX FIFO.
module edge_frame_tx #(
    parameter int unsigned H_RES     = edge_tx_pkg::H_RES_DEFAULT,
    parameter int unsigned V_RES     = edge_tx_pkg::V_RES_DEFAULT,
    parameter int unsigned TH        = edge_tx_pkg::TH_DEFAULT,
    parameter logic [7:0]  SYNC_BYTE = edge_tx_pkg::SYNC_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_de,
    input  logic [7:0] i_pix,
    input  logic       tx_fifo_full,
    output logic       tx_push,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_sent,
    output logic       drop_px
);

    import edge_tx_pkg::*;

    localparam int unsigned FRAME_PIX   = H_RES * V_RES;
    localparam int unsigned FRAME_BYTES = FRAME_PIX / 8;
    localparam int unsigned BAW         = $clog2(FRAME_BYTES);

    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [7:0]        TH_B      = 8'(TH);

    state_e              state_q, state_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [6:0]          shift_q, shift_d;

    logic                ram_we, ram_re;
    logic [7:0]          ram_rdata;
    logic [7:0]          packed_byte;
    logic                push_c, sent_c, drop_c;
    logic [7:0]          data_c;

    // Seven earlier bits live in shift_q; the incoming bit completes the byte.
    assign packed_byte = {shift_q, (i_pix >= TH_B)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CAP;
            pix_cnt_q <= '0;
            rd_addr_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            rd_addr_q <= rd_addr_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        rd_addr_d = rd_addr_q;
        shift_d   = shift_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        push_c    = 1'b0;
        sent_c    = 1'b0;
        drop_c    = 1'b0;
        data_c    = '0;

        case (state_q)
            ST_CAP: begin
                if (i_de) begin
                    shift_d = packed_byte[6:0];
                    ram_we  = (pix_cnt_q[2:0] == 3'd7);
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d = ST_HDR;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
            end
            ST_HDR: begin
                drop_c = i_de;
                data_c = SYNC_BYTE;
                push_c = !tx_fifo_full;
                if (!tx_fifo_full) begin
                    rd_addr_d = '0;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                drop_c  = i_de;
                ram_re  = 1'b1;
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                // Read register is only reloaded in RD, so data holds while stalled.
                drop_c = i_de;
                data_c = ram_rdata;
                push_c = !tx_fifo_full;
                if (!tx_fifo_full) begin
                    if (rd_addr_q == LAST_BYTE) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                drop_c    = i_de;
                sent_c    = 1'b1;
                pix_cnt_d = '0;
                rd_addr_d = '0;
                shift_d   = '0;
                state_d   = ST_CAP;
            end
            default: begin
                state_d = ST_CAP;
            end
        endcase
    end

    // Outputs are forced quiet during the reset cycle itself.
    assign tx_push    = push_c && !reset;
    assign tx_data    = reset ? 8'h00 : data_c;
    assign frame_sent = sent_c && !reset;
    assign drop_px    = drop_c && !reset;
    assign busy       = !reset && ((state_q != ST_CAP) || (pix_cnt_q != '0));

    edge_tx_ram #(
        .DEPTH (FRAME_BYTES),
        .AW    (BAW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (pix_cnt_q[3 +: BAW]),
        .wdata_i (packed_byte),
        .re_i    (ram_re),
        .raddr_i (rd_addr_q[BAW-1:0]),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_edge_frame_tx.sv
// Directed bench for edge_frame_tx on a reduced 40x8 frame (40 bytes).
// A negedge monitor collects pushed bytes and pulse counts for the main sequence.
module tb_edge_frame_tx;

    localparam int unsigned H  = 40;
    localparam int unsigned V  = 8;
    localparam int unsigned NP = H * V;
    localparam int unsigned NB = NP / 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_de = 1'b0;
    logic [7:0] i_pix = 8'h00;
    logic       tx_fifo_full = 1'b0;
    logic       tx_push;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_sent;
    logic       drop_px;

    int errors = 0;
    int checks = 0;
    int sent_cnt = 0;
    int drop_cnt = 0;
    logic [7:0] rx_q[$];

    edge_frame_tx #(
        .H_RES     (H),
        .V_RES     (V),
        .TH        (128),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_de         (i_de),
        .i_pix        (i_pix),
        .tx_fifo_full (tx_fifo_full),
        .tx_push      (tx_push),
        .tx_data      (tx_data),
        .busy         (busy),
        .frame_sent   (frame_sent),
        .drop_px      (drop_px)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_push) begin
            rx_q.push_back(tx_data);
            checks++;
            assert (tx_fifo_full === 1'b0) else begin
                errors++;
                $error("FAIL push_while_full observed=%0b expected=0", tx_fifo_full);
            end
        end
        if (frame_sent) sent_cnt++;
        if (drop_px)    drop_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int mode, input int p);
        case (mode)
            0:       return 8'd255;
            1:       return (p % 2 == 1) ? 8'd10 : 8'd200;
            2:       return (p % 2 == 1) ? 8'd127 : 8'd128;
            3:       return 8'd127;
            default: return 8'((p * 37 + 11) & 255);
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int b);
        logic [7:0] r;
        case (mode)
            0: return 8'hFF;
            1: return 8'hAA;
            2: return 8'hAA;
            3: return 8'h00;
            default: begin
                r = 8'h00;
                for (int k = 0; k < 8; k++) r = {r[6:0], (pix_of(mode, b * 8 + k) >= 8'd128)};
                return r;
            end
        endcase
    endfunction

    task automatic feed(input int mode, input bit gaps);
        for (int p = 0; p < int'(NP); p++) begin
            if (gaps && (p % 5 == 3)) begin
                i_de  = 1'b0;
                i_pix = 8'hFF;
                tick();
            end
            i_de  = 1'b1;
            i_pix = pix_of(mode, p);
            tick();
        end
        i_de = 1'b0;
    endtask

    task automatic wait_sent(input string tag, input int target);
        int n;
        n = 0;
        while (sent_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_sent"}, sent_cnt, target);
        tick();
        tick();
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_one_pulse"}, sent_cnt, target);
    endtask

    task automatic check_stream(input string tag, input int mode);
        chk({tag, "_count"}, rx_q.size(), NB + 1);
        if (rx_q.size() == NB + 1) begin
            chk({tag, "_hdr"}, rx_q[0], 8'hA5);
            for (int b = 0; b < int'(NB); b++) begin
                chk($sformatf("%s_byte%0d", tag, b), rx_q[b + 1], exp_byte(mode, b));
            end
        end
        rx_q.delete();
    endtask

    initial begin
        int n;
        int drops0;
        int sent0;
        logic [7:0] hold;

        // Reset with stray pixel activity: every output must stay low.
        i_de  = 1'b1;
        i_pix = 8'hFF;
        tick(); tick(); tick();
        chk("rst_push", tx_push, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sent", frame_sent, 1'b0);
        chk("rst_drop", drop_px, 1'b0);
        reset = 1'b0;
        i_de  = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_data", tx_data, 8'h00);

        feed(0, 1'b0);
        chk("hdr_busy", busy, 1'b1);
        wait_sent("all255", 1);
        check_stream("all255", 0);

        feed(1, 1'b0);
        wait_sent("alt200", 2);
        check_stream("alt200", 1);

        feed(2, 1'b0);
        wait_sent("th128", 3);
        check_stream("th128", 2);

        feed(3, 1'b0);
        wait_sent("all127", 4);
        check_stream("all127", 3);

        feed(4, 1'b1);
        wait_sent("ramp_gaps", 5);
        check_stream("ramp_gaps", 4);

        // Back-pressure for 10 cycles while byte 37 is presented.
        feed(4, 1'b0);
        n = 0;
        while (rx_q.size() < 38 && n < 500) begin
            tick();
            n++;
        end
        chk("stall_reach", rx_q.size(), 38);
        tx_fifo_full = 1'b1;
        tick();
        hold = tx_data;
        chk("stall_byte37", hold, exp_byte(4, 37));
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall_nopush%0d", c), tx_push, 1'b0);
            chk($sformatf("stall_hold%0d", c), tx_data, hold);
            if (c < 9) tick();
        end
        tx_fifo_full = 1'b0;
        wait_sent("stall", 6);
        check_stream("stall", 4);

        // Pixel pulses during send: first one lands in HDR.
        drops0 = drop_cnt;
        feed(4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            i_de  = 1'b1;
            i_pix = 8'h00;
            tick();
            i_de = 1'b0;
            tick(); tick(); tick();
        end
        wait_sent("drop", 7);
        chk("drop_count", drop_cnt - drops0, 5);
        check_stream("drop", 4);

        // Reset after a partial capture, then a clean frame.
        for (int p = 0; p < 100; p++) begin
            i_de  = 1'b1;
            i_pix = 8'h00;
            tick();
        end
        i_de = 1'b0;
        chk("partial_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("partial_rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        chk("partial_nopush", rx_q.size(), 0);
        feed(0, 1'b0);
        wait_sent("after_cap_rst", 8);
        check_stream("after_cap_rst", 0);

        // Reset in the middle of sending.
        feed(3, 1'b0);
        n = 0;
        while (rx_q.size() < 10 && n < 500) begin
            tick();
            n++;
        end
        chk("midsend_reach", rx_q.size(), 10);
        sent0 = sent_cnt;
        reset = 1'b1;
        #1;
        chk("midsend_rst_push", tx_push, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("midsend_no_sent", sent_cnt, sent0);
        rx_q.delete();
        feed(2, 1'b0);
        wait_sent("after_send_rst", sent0 + 1);
        check_stream("after_send_rst", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
